scan_result_fifo: RTL and testbench

//  Buffers per-step results from the counter (32b time, 32b signals) between the counter and eth_top.

---
 rtl/scan_result_fifo_if.sv | 36 +++
 rtl/scan_result_fifo.sv | 114 +++++++++++
 tb/tb_scan_result_fifo.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_result_fifo_if.sv
// Command-bus and step-result signals shared between the counter,
// the command block, eth_top and the result FIFO.
//
// Handshake semantics: push and pop are single-cycle strobes sampled on the
// rising clock edge; there is no ready back-pressure.  A push is taken only
// while the FIFO is enabled and has room (or a pop is taken in the same
// cycle).  A pop is taken only while the FIFO is not empty.  An accepted pop
// is answered one cycle later by a one-cycle out_valid pulse with
// time_out/signals_out updated.
interface scan_result_fifo_if;
   logic [7:0]  addr;
   logic [7:0]  data;
   logic        write;
   logic [7:0]  data_out;
   logic        push;
   logic [31:0] time_in;
   logic [31:0] signals_in;
   logic        pop;
   logic [31:0] time_out;
   logic [31:0] signals_out;
   logic        out_valid;
   logic        empty;
   logic        full;

   // Drives the FIFO: command bus, counter and eth_top side
   modport master (
      output addr, data, write, push, time_in, signals_in, pop,
      input  data_out, time_out, signals_out, out_valid, empty, full
   );

   // The FIFO itself
   modport slave (
      input  addr, data, write, push, time_in, signals_in, pop,
      output data_out, time_out, signals_out, out_valid, empty, full
   );
endinterface

// File: rtl/scan_result_fifo.sv
// Per-step result FIFO between the step counter and eth_top.
// Each entry is {time, signals}.  Control/status lives at ADDR_BASE on the
// 8-bit command bus, the fill level at ADDR_BASE+1.
module scan_result_fifo #(
   parameter int          DEPTH     = 16,
   parameter logic [7:0]  ADDR_BASE = 8'h40
) (
   input  logic              clock50Mhz,
   input  logic              reset,
   scan_result_fifo_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = AW + 1;

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic          overflow;
   logic          enable;
   logic [31:0]   time_q;
   logic [31:0]   signals_q;
   logic          out_valid_q;

   logic          ctrl_wr;
   logic          flush;
   logic          empty_i;
   logic          full_i;
   logic          pop_ok;
   logic          push_ok;
   logic          push_drop;
   logic [15:0]   level_wide;

   // Decode command-bus control and the push/pop acceptance rules
   always_comb begin
      ctrl_wr   = bus.write && (bus.addr == ADDR_BASE);
      flush     = ctrl_wr && bus.data[0];
      empty_i   = (level == '0);
      full_i    = (level == LW'(DEPTH));
      pop_ok    = bus.pop && !empty_i && !flush;
      // A pop in the same cycle frees a slot, so a full FIFO can still take a push
      push_ok   = bus.push && enable && (!full_i || pop_ok) && !flush;
      push_drop = bus.push && enable && full_i && !pop_ok && !flush;
   end

   // Pointers, level, sticky overflow, enable and the registered pop outputs
   always_ff @(posedge clock50Mhz) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         overflow    <= 1'b0;
         enable      <= 1'b0;
         time_q      <= '0;
         signals_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= pop_ok;
         if (ctrl_wr) begin
            enable <= bus.data[1];
         end
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
         end else begin
            if (push_ok) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
               rd_ptr    <= rd_ptr + 1'b1;
               time_q    <= mem[rd_ptr][63:32];
               signals_q <= mem[rd_ptr][31:0];
            end
            if (push_ok && !pop_ok) begin
               level <= level + 1'b1;
            end else if (pop_ok && !push_ok) begin
               level <= level - 1'b1;
            end
            if (push_drop) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // Entry storage; contents need no reset since level gates every read
   always_ff @(posedge clock50Mhz) begin
      if (push_ok) begin
         mem[wr_ptr] <= {bus.time_in, bus.signals_in};
      end
   end

   // Register readback mux for the selector
   always_comb begin
      level_wide = 16'(level);
      if (bus.addr == ADDR_BASE) begin
         bus.data_out = {overflow, full_i, empty_i, enable, 4'b0000};
      end else if (bus.addr == ADDR_BASE + 8'd1) begin
         bus.data_out = level_wide[7:0];
      end else begin
         bus.data_out = 8'h00;
      end
   end

   assign bus.time_out    = time_q;
   assign bus.signals_out = signals_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.empty       = empty_i;
   assign bus.full        = full_i;

endmodule

// File: tb/tb_scan_result_fifo.sv
// Directed bench for scan_result_fifo with DEPTH=16, ADDR_BASE=8'h40.
module tb_scan_result_fifo;

   logic clock50Mhz;
   logic reset;
   int   checks;
   int   errors;

   scan_result_fifo_if bus ();

   scan_result_fifo #(
      .DEPTH     (16),
      .ADDR_BASE (8'h40)
   ) dut (
      .clock50Mhz (clock50Mhz),
      .reset      (reset),
      .bus        (bus.slave)
   );

   // 50 MHz clock
   initial begin
      clock50Mhz = 1'b0;
      forever #10 clock50Mhz = ~clock50Mhz;
   end

   // Advance one clock; outputs are settled 1 ns after the edge
   task automatic tick();
      @(posedge clock50Mhz);
      #1;
   endtask

   task automatic idle_inputs();
      bus.addr       = 8'h00;
      bus.data       = 8'h00;
      bus.write      = 1'b0;
      bus.push       = 1'b0;
      bus.time_in    = '0;
      bus.signals_in = '0;
      bus.pop        = 1'b0;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
      bus.addr  = a;
      bus.data  = d;
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
      bus.data  = 8'h00;
   endtask

   task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
      bus.addr = a;
      #1;
      v = bus.data_out;
   endtask

   task automatic do_push(input logic [31:0] t, input logic [31:0] s);
      bus.push       = 1'b1;
      bus.time_in    = t;
      bus.signals_in = s;
      tick();
      bus.push       = 1'b0;
   endtask

   task automatic do_pop();
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.empty !== 1'b1) begin
         errors++; $display("FAIL reset_empty got %b want 1", bus.empty);
      end
      checks++;
      if (bus.full !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_full_valid got %b%b want 00", bus.full, bus.out_valid);
      end
      checks++;
      if (bus.time_out !== 32'd0 || bus.signals_out !== 32'd0) begin
         errors++; $display("FAIL reset_outputs got %0d/%0d want 0/0", bus.time_out, bus.signals_out);
      end
      read_reg(8'h40, v);
      checks++;
      if (v !== 8'h20) begin
         errors++; $display("FAIL reset_status got %h want 20", v);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] v;
      wr_reg(8'h40, 8'h02);
      read_reg(8'h40, v);
      checks++;
      if (v !== 8'h30) begin
         errors++; $display("FAIL basic_enable_status got %h want 30", v);
      end
      for (int i = 1; i <= 3; i++) do_push(32'(i), 32'(10 * i));
      read_reg(8'h41, v);
      checks++;
      if (v !== 8'd3) begin
         errors++; $display("FAIL basic_level3 got %0d want 3", v);
      end
      for (int i = 1; i <= 3; i++) begin
         do_pop();
         read_reg(8'h41, v);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.time_out !== 32'(i) ||
             bus.signals_out !== 32'(10 * i) || v !== 8'(3 - i)) begin
            errors++;
            $display("FAIL basic_pop%0d got v=%b t=%0d s=%0d lvl=%0d want v=1 t=%0d s=%0d lvl=%0d",
                     i, bus.out_valid, bus.time_out, bus.signals_out, v, i, 10 * i, 3 - i);
         end
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_valid_pulse got %b want 0", bus.out_valid);
      end
      do_pop();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.time_out !== 32'd3 || bus.signals_out !== 32'd30) begin
         errors++;
         $display("FAIL basic_pop_empty got v=%b t=%0d s=%0d want v=0 t=3 s=30",
                  bus.out_valid, bus.time_out, bus.signals_out);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      logic [7:0] lv;
      for (int i = 1; i <= 17; i++) do_push(32'(i), 32'(100 + i));
      read_reg(8'h40, v);
      read_reg(8'h41, lv);
      checks++;
      if (v !== 8'hD0 || lv !== 8'd16 || bus.full !== 1'b1) begin
         errors++; $display("FAIL ovf_status got %h lvl=%0d full=%b want D0 16 1", v, lv, bus.full);
      end
      for (int i = 1; i <= 16; i++) begin
         do_pop();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.time_out !== 32'(i) || bus.signals_out !== 32'(100 + i)) begin
            errors++;
            $display("FAIL ovf_pop%0d got v=%b t=%0d s=%0d want v=1 t=%0d s=%0d",
                     i, bus.out_valid, bus.time_out, bus.signals_out, i, 100 + i);
         end
      end
      read_reg(8'h40, v);
      checks++;
      if (v !== 8'hB0) begin
         errors++; $display("FAIL ovf_sticky got %h want B0", v);
      end
      wr_reg(8'h40, 8'h03);
      read_reg(8'h40, v);
      checks++;
      if (v !== 8'h30) begin
         errors++; $display("FAIL ovf_flush_clear got %h want 30", v);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] v;
      logic [7:0] lv;
      for (int i = 1; i <= 16; i++) do_push(32'(200 + i), 32'(i));
      bus.push       = 1'b1;
      bus.time_in    = 32'd300;
      bus.signals_in = 32'd77;
      bus.pop        = 1'b1;
      tick();
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      read_reg(8'h40, v);
      read_reg(8'h41, lv);
      checks++;
      if (lv !== 8'd16 || v !== 8'h50 || bus.time_out !== 32'd201 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL fullpp_state got lvl=%0d st=%h t=%0d v=%b want 16 50 201 1",
                  lv, v, bus.time_out, bus.out_valid);
      end
      for (int i = 2; i <= 17; i++) begin
         do_pop();
         checks++;
         if (bus.time_out !== ((i == 17) ? 32'd300 : 32'(200 + i)) ||
             bus.signals_out !== ((i == 17) ? 32'd77 : 32'(i))) begin
            errors++;
            $display("FAIL fullpp_drain%0d got t=%0d s=%0d", i, bus.time_out, bus.signals_out);
         end
      end
      checks++;
      if (bus.empty !== 1'b1) begin
         errors++; $display("FAIL fullpp_empty got %b want 1", bus.empty);
      end
   endtask

   task automatic test_flush();
      logic [7:0] v;
      logic [7:0] lv;
      for (int i = 1; i <= 5; i++) do_push(32'(400 + i), 32'(i));
      bus.addr       = 8'h40;
      bus.data       = 8'h03;
      bus.write      = 1'b1;
      bus.push       = 1'b1;
      bus.time_in    = 32'd999;
      bus.signals_in = 32'd999;
      tick();
      bus.write = 1'b0;
      bus.push  = 1'b0;
      read_reg(8'h40, v);
      read_reg(8'h41, lv);
      checks++;
      if (lv !== 8'd0 || v !== 8'h30 || bus.empty !== 1'b1) begin
         errors++; $display("FAIL flush_state got lvl=%0d st=%h want 0 30", lv, v);
      end
      do_push(32'd500, 32'd50);
      wr_reg(8'h42, 8'h01);
      read_reg(8'h41, lv);
      read_reg(8'h42, v);
      checks++;
      if (lv !== 8'd1 || v !== 8'h00) begin
         errors++; $display("FAIL flush_other_addr got lvl=%0d rd=%h want 1 00", lv, v);
      end
      do_pop();
      checks++;
      if (bus.time_out !== 32'd500 || bus.signals_out !== 32'd50) begin
         errors++; $display("FAIL flush_lost_entry got t=%0d s=%0d want 500 50", bus.time_out, bus.signals_out);
      end
      wr_reg(8'h40, 8'h00);
      do_push(32'd600, 32'd60);
      read_reg(8'h40, v);
      checks++;
      if (v !== 8'h20) begin
         errors++; $display("FAIL disabled_push got %h want 20", v);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      logic [7:0] lv;
      wr_reg(8'h40, 8'h02);
      for (int i = 1; i <= 8; i++) do_push(32'(700 + i), 32'(i));
      read_reg(8'h41, lv);
      checks++;
      if (lv !== 8'd8) begin
         errors++; $display("FAIL mid_level8 got %0d want 8", lv);
      end
      bus.pop = 1'b1;
      reset   = 1'b0;
      tick();
      bus.pop = 1'b0;
      read_reg(8'h40, v);
      checks++;
      if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || v !== 8'h20 || bus.time_out !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset got e=%b v=%b st=%h t=%0d want 1 0 20 0",
                  bus.empty, bus.out_valid, v, bus.time_out);
      end
      reset = 1'b1;
      do_push(32'd800, 32'd80);
      read_reg(8'h41, lv);
      checks++;
      if (lv !== 8'd0) begin
         errors++; $display("FAIL mid_push_ignored got %0d want 0", lv);
      end
      wr_reg(8'h40, 8'h02);
      do_push(32'd801, 32'd81);
      read_reg(8'h41, lv);
      checks++;
      if (lv !== 8'd1) begin
         errors++; $display("FAIL mid_reenabled got %0d want 1", lv);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      idle_inputs();
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
